// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, frame length and common
// keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SETUP,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam int FRAME_EDGES = 11;

    localparam logic [7:0] CMD_LEDS   = 8'hED;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a one-cycle
// pulse on each synchronized falling edge of the PS/2 clock.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic clock_pin,
    input  logic data_pin,
    output logic clock_sync,
    output logic data_sync,
    output logic clock_fall
);

    logic clock_meta;
    logic clock_d0;
    logic clock_d1;
    logic data_meta;
    logic data_d0;

    // Idle bus lines are pulled high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clock_meta <= 1'b1;
            clock_d0   <= 1'b1;
            clock_d1   <= 1'b1;
            data_meta  <= 1'b1;
            data_d0    <= 1'b1;
        end else begin
            clock_meta <= clock_pin;
            clock_d0   <= clock_meta;
            clock_d1   <= clock_d0;
            data_meta  <= data_pin;
            data_d0    <= data_meta;
        end
    end

    assign clock_sync = clock_d0;
    assign data_sync  = data_d0;
    assign clock_fall = clock_d1 & ~clock_d0;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame shifted out
// on device clocks, acknowledge check and timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PHASE_W-1:0]   INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0]   SETUP_LAST   = PHASE_W'(SETUP_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]           STOP_PRIOR   = 4'(FRAME_EDGES - 2);

    logic clock_sync;
    logic data_sync;
    logic clock_fall;

    state_t               state;
    logic [PHASE_W-1:0]   phase_count;
    logic [TIMEOUT_W-1:0] timeout_count;
    logic [3:0]           edge_count;
    logic [8:0]           shift_reg;
    logic                 timeout_hit;

    ps2_sync_edge u_sync (
        .clock      (clock),
        .reset      (reset),
        .clock_pin  (ps2_clock_in),
        .data_pin   (ps2_data_in),
        .clock_sync (clock_sync),
        .data_sync  (data_sync),
        .clock_fall (clock_fall)
    );

    assign timeout_hit = (timeout_count == TIMEOUT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            phase_count   <= '0;
            timeout_count <= '0;
            edge_count    <= '0;
            shift_reg     <= '0;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
            tx_error      <= 1'b0;
            ps2_clock_oe  <= 1'b0;
            ps2_data_oe   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clock_oe <= 1'b0;
                    ps2_data_oe  <= 1'b0;
                    if (tx_start) begin
                        shift_reg    <= {odd_parity(tx_data), tx_data};
                        phase_count  <= '0;
                        edge_count   <= '0;
                        tx_busy      <= 1'b1;
                        ps2_clock_oe <= 1'b1;
                        state        <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (phase_count == INHIBIT_LAST) begin
                        phase_count <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= SETUP;
                    end else begin
                        phase_count <= phase_count + 1'b1;
                    end
                end
                SETUP: begin
                    timeout_count <= '0;
                    if (phase_count == SETUP_LAST) begin
                        ps2_clock_oe <= 1'b0;
                        state        <= SEND;
                    end else begin
                        phase_count <= phase_count + 1'b1;
                    end
                end
                SEND: begin
                    if (timeout_hit) begin
                        tx_error     <= 1'b1;
                        tx_busy      <= 1'b0;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                        if (clock_fall) begin
                            edge_count <= edge_count + 1'b1;
                            // The tenth edge releases data as the stop bit.
                            if (edge_count == STOP_PRIOR) begin
                                ps2_data_oe <= 1'b0;
                                state       <= ACK;
                            end else begin
                                ps2_data_oe <= ~shift_reg[0];
                                shift_reg   <= {1'b0, shift_reg[8:1]};
                            end
                        end
                    end
                end
                ACK: begin
                    // The acknowledge edge takes priority over a coincident timeout.
                    if (clock_fall) begin
                        edge_count <= edge_count + 1'b1;
                        if (data_sync) begin
                            tx_error <= 1'b1;
                            tx_busy  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            timeout_count <= timeout_count + 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end else if (timeout_hit) begin
                        tx_error     <= 1'b1;
                        tx_busy      <= 1'b0;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (clock_sync && data_sync) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end else if (timeout_hit) begin
                        tx_error     <= 1'b1;
                        tx_busy      <= 1'b0;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                default: begin
                    tx_busy      <= 1'b0;
                    ps2_clock_oe <= 1'b0;
                    ps2_data_oe  <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a device model clocks frames and checks
// each transmitted bit, a monitor checks every done/error pulse.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 20;
    localparam int SETUP   = 5;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 6;

    localparam int RES_NONE    = 0;
    localparam int RES_DONE    = 1;
    localparam int RES_ERROR   = 2;
    localparam int RES_TIMEOUT = 3;

    localparam int MODE_SILENT = 0;
    localparam int MODE_ACK    = 1;
    localparam int MODE_NACK   = 2;
    localparam int MODE_ABORT  = 3;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clock_oe;
    logic       ps2_data_oe;
    logic       dev_clock = 1'b1;
    logic       dev_data  = 1'b1;
    logic       ps2_clock_line;
    logic       ps2_data_line;

    int   checks     = 0;
    int   errors     = 0;
    int   cycle      = 0;
    int   fall_cycle = 0;
    int   dev_mode   = MODE_ACK;
    bit   reset_done = 0;
    bit   abort_seen = 0;
    logic prev_clock_oe = 1'b0;

    logic bit_q[$];
    int   result_q[$];

    assign ps2_clock_line = ~ps2_clock_oe & dev_clock;
    assign ps2_data_line  = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error),
        .ps2_clock_in (ps2_clock_line),
        .ps2_data_in  (ps2_data_line),
        .ps2_clock_oe (ps2_clock_oe),
        .ps2_data_oe  (ps2_data_oe)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic pop_bit(input string name);
        logic exp;
        if (bit_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got a bit with %0d expected bits queued", name, 0);
        end else begin
            exp = bit_q.pop_front();
            check_output(name, int'(ps2_data_line), int'(exp));
        end
    endtask

    // Device model: clocks the frame and scores each bit while the clock is low.
    task automatic device_frame(input int mode);
        repeat (2) @(negedge clock);
        pop_bit("start_bit");
        for (int e = 1; e <= FRAME_EDGES; e++) begin
            repeat (HALF) @(negedge clock);
            dev_clock = 1'b0;
            repeat (HALF) @(negedge clock);
            if (e < FRAME_EDGES) pop_bit($sformatf("edge%0d_bit", e));
            dev_clock = 1'b1;
            if (mode == MODE_ABORT && e == 5) begin
                abort_seen = 1;
                return;
            end
            if (mode == MODE_ACK && e == FRAME_EDGES - 1) dev_data = 1'b0;
        end
        repeat (2) @(negedge clock);
        dev_data = 1'b1;
    endtask

    initial begin
        wait (reset_done);
        forever begin
            @(negedge ps2_clock_oe);
            if (dev_mode != MODE_SILENT) device_frame(dev_mode);
        end
    end

    // Monitor: every completion pulse is matched against the expected result.
    initial begin
        int exp;
        int got;
        forever begin
            @(negedge clock);
            if (prev_clock_oe && !ps2_clock_oe) fall_cycle = cycle;
            prev_clock_oe = ps2_clock_oe;
            if (tx_done || tx_error) begin
                got = (tx_done && tx_error) ? 99 : (tx_done ? RES_DONE : RES_ERROR);
                if (result_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: got kind %0d expected no pulse", got);
                end else begin
                    exp = result_q.pop_front();
                    check_output("result_kind", got, (exp == RES_TIMEOUT) ? RES_ERROR : exp);
                    if (exp == RES_TIMEOUT)
                        check_output("timeout_latency", cycle - fall_cycle, TIMEOUT);
                    check_output("pulse_busy", int'(tx_busy), 0);
                    check_output("pulse_clock_oe", int'(ps2_clock_oe), 0);
                    check_output("pulse_data_oe", int'(ps2_data_oe), 0);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] data, input logic parity, input int result);
        @(negedge clock);
        tx_data  = data;
        tx_start = 1'b1;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(data[i]);
        bit_q.push_back(parity);
        bit_q.push_back(1'b1);
        if (result != RES_NONE) result_q.push_back(result);
        @(negedge clock);
        tx_start = 1'b0;
        check_output("accept_busy", int'(tx_busy), 1);
        check_output("inhibit_clock_oe", int'(ps2_clock_oe), 1);
        check_output("inhibit_data_oe", int'(ps2_data_oe), 0);
        repeat (INHIBIT - 1) @(negedge clock);
        check_output("inhibit_last_data_oe", int'(ps2_data_oe), 0);
        @(negedge clock);
        check_output("setup_data_oe", int'(ps2_data_oe), 1);
        check_output("setup_clock_oe", int'(ps2_clock_oe), 1);
        repeat (SETUP) @(negedge clock);
        check_output("send_clock_oe", int'(ps2_clock_oe), 0);
        check_output("send_start_oe", int'(ps2_data_oe), 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((result_q.size() != 0 || tx_busy) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check_output({name, "_finished"}, int'(n < 2000), 1);
        repeat (10) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check_output("reset_busy", int'(tx_busy), 0);
        check_output("reset_done", int'(tx_done), 0);
        check_output("reset_error", int'(tx_error), 0);
        check_output("reset_clock_oe", int'(ps2_clock_oe), 0);
        check_output("reset_data_oe", int'(ps2_data_oe), 0);
        reset = 1'b0;
        reset_done = 1;
        repeat (5) @(negedge clock);

        $display("[TB] frame 0xED with acknowledge");
        dev_mode = MODE_ACK;
        apply_stimulus(CMD_LEDS, 1'b1, RES_DONE);
        wait_idle("leds");

        $display("[TB] frame 0xF4 with acknowledge");
        apply_stimulus(CMD_ENABLE, 1'b0, RES_DONE);
        wait_idle("enable");

        $display("[TB] frame 0xED without acknowledge");
        dev_mode = MODE_NACK;
        apply_stimulus(CMD_LEDS, 1'b1, RES_ERROR);
        wait_idle("nack");

        $display("[TB] silent device timeout");
        dev_mode = MODE_SILENT;
        apply_stimulus(CMD_ENABLE, 1'b0, RES_TIMEOUT);
        wait_idle("timeout");
        bit_q.delete();

        $display("[TB] second start while busy");
        dev_mode = MODE_ACK;
        apply_stimulus(CMD_RESET, 1'b1, RES_DONE);
        repeat (30) @(negedge clock);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        check_output("ignored_start_busy", int'(tx_busy), 1);
        wait_idle("busy_drop");

        $display("[TB] reset after edge 5");
        dev_mode = MODE_ABORT;
        apply_stimulus(CMD_RESET, 1'b1, RES_NONE);
        n = 0;
        while (!abort_seen && n < 500) begin
            @(negedge clock);
            n++;
        end
        check_output("abort_reached", int'(abort_seen), 1);
        #2 reset = 1'b1;
        #1;
        check_output("abort_clock_oe", int'(ps2_clock_oe), 0);
        check_output("abort_data_oe", int'(ps2_data_oe), 0);
        check_output("abort_busy", int'(tx_busy), 0);
        check_output("abort_done", int'(tx_done), 0);
        check_output("abort_error", int'(tx_error), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        bit_q.delete();
        repeat (50) @(negedge clock);

        $display("[TB] fresh 0xFF after reset");
        dev_mode = MODE_ACK;
        apply_stimulus(CMD_RESET, 1'b1, RES_DONE);
        wait_idle("after_reset");

        check_output("bits_consumed", bit_q.size(), 0);
        check_output("results_consumed", result_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
